// File: rtl/demux_1to4_tdm.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to4_tdm
// Purpose  : Receive-side 1:4 TDM demultiplexer. Locks to the slot-0 sync
//            marker and presents each complete 4-slot frame as four
//            registered lane words with a one-cycle out_valid pulse.
// Options  : DEMUX_SYNC_CHECK_EN - when defined, a missing sync at slot 0
//            while locked flags frame_err and drops back to hunting.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1to4_tdm #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid,
    output logic             frame_err,
    output logic             locked
);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] sh0_q, sh0_d;
    logic [WIDTH-1:0] sh1_q, sh1_d;
    logic [WIDTH-1:0] sh2_q, sh2_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic [WIDTH-1:0] out3_q, out3_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        out3_d      = out3_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        sh0_d   = in;
                        slot_d  = 2'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // A sync anywhere but slot 0 abandons the partial frame
                        frame_err_d = (slot_q != 2'd0);
                        sh0_d       = in;
                        slot_d      = 2'd1;
                    end else if (slot_q == 2'd0) begin
`ifdef DEMUX_SYNC_CHECK_EN
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                        slot_d      = 2'd0;
`else
                        sh0_d       = in;
                        slot_d      = 2'd1;
`endif
                    end else begin
                        case (slot_q)
                            2'd1: begin
                                sh1_d  = in;
                                slot_d = 2'd2;
                            end
                            2'd2: begin
                                sh2_d  = in;
                                slot_d = 2'd3;
                            end
                            default: begin
                                out0_d      = sh0_q;
                                out1_d      = sh1_q;
                                out2_d      = sh2_q;
                                out3_d      = in;
                                out_valid_d = 1'b1;
                                slot_d      = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            slot_q      <= 2'd0;
            sh0_q       <= '0;
            sh1_q       <= '0;
            sh2_q       <= '0;
            out0_q      <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            out3_q      <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            out3_q      <= out3_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out0      = out0_q;
    assign out1      = out1_q;
    assign out2      = out2_q;
    assign out3      = out3_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign locked    = (state_q == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_demux_1to4_tdm.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to4_tdm
// Purpose  : Directed vector bench for demux_1to4_tdm (WIDTH=4); expectations
//            for the slot-0 missing-sync case follow DEMUX_SYNC_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1to4_tdm;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             sync;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic             out_valid, frame_err, locked;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demux_1to4_tdm #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .sync      (sync),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .locked    (locked)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic        s;
        logic [3:0]  d;
        logic [15:0] outs;   // {out0,out1,out2,out3} after the edge
        logic        ov;
        logic        fe;
        logic        lk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic v, input logic s, input logic [3:0] d,
                       input logic [15:0] outs, input logic ov, input logic fe, input logic lk);
        vec_t t;
        t.rst = rst; t.v = v; t.s = s; t.d = d;
        t.outs = outs; t.ov = ov; t.fe = fe; t.lk = lk;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [15:0] eo,
                         input logic eov, input logic efe, input logic elk);
        checks++;
        if ({out0, out1, out2, out3} !== eo || out_valid !== eov ||
            frame_err !== efe || locked !== elk) begin
            errors++;
            $display("FAIL %s: got outs=%h ov=%b fe=%b lk=%b, expected outs=%h ov=%b fe=%b lk=%b",
                     name, {out0, out1, out2, out3}, out_valid, frame_err, locked,
                     eo, eov, efe, elk);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic s, input logic [3:0] d);
        reset = rst; in_valid = v; sync = s; in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; sync = 1'b0; in = '0;

        // Reset with a valid sync sample present: reset must win
        add(1, 1, 1, 4'hF, 16'h0000, 0, 0, 0);
        add(0, 0, 0, 4'h0, 16'h0000, 0, 0, 0);
        // Basic frame A,B,C,D
        add(0, 1, 1, 4'hA, 16'h0000, 0, 0, 1);
        add(0, 1, 0, 4'hB, 16'h0000, 0, 0, 1);
        add(0, 1, 0, 4'hC, 16'h0000, 0, 0, 1);
        add(0, 1, 0, 4'hD, 16'hABCD, 1, 0, 1);
        add(0, 0, 0, 4'h0, 16'hABCD, 0, 0, 1);
        // Reset, then samples before the first sync are discarded
        add(1, 0, 0, 4'h0, 16'h0000, 0, 0, 0);
        add(0, 1, 0, 4'h5, 16'h0000, 0, 0, 0);
        add(0, 1, 0, 4'h6, 16'h0000, 0, 0, 0);
        add(0, 1, 1, 4'h1, 16'h0000, 0, 0, 1);
        add(0, 1, 0, 4'h2, 16'h0000, 0, 0, 1);
        add(0, 1, 0, 4'h3, 16'h0000, 0, 0, 1);
        add(0, 1, 0, 4'h4, 16'h1234, 1, 0, 1);
        // Early sync at slot 2 drops the partial frame 1,2
        add(0, 1, 1, 4'h1, 16'h1234, 0, 0, 1);
        add(0, 1, 0, 4'h2, 16'h1234, 0, 0, 1);
        add(0, 1, 1, 4'h9, 16'h1234, 0, 1, 1);
        add(0, 1, 0, 4'hA, 16'h1234, 0, 0, 1);
        add(0, 1, 0, 4'hB, 16'h1234, 0, 0, 1);
        add(0, 1, 0, 4'hC, 16'h9ABC, 1, 0, 1);
        // Frame with in_valid gaps
        add(0, 1, 1, 4'h5, 16'h9ABC, 0, 0, 1);
        add(0, 0, 1, 4'hE, 16'h9ABC, 0, 0, 1);
        add(0, 0, 0, 4'hE, 16'h9ABC, 0, 0, 1);
        add(0, 1, 0, 4'h6, 16'h9ABC, 0, 0, 1);
        add(0, 0, 0, 4'hE, 16'h9ABC, 0, 0, 1);
        add(0, 1, 0, 4'h7, 16'h9ABC, 0, 0, 1);
        add(0, 1, 0, 4'h8, 16'h5678, 1, 0, 1);
        add(0, 0, 0, 4'h0, 16'h5678, 0, 0, 1);
        // Back-to-back frames, second lacks sync on slot 0
        add(0, 1, 1, 4'h1, 16'h5678, 0, 0, 1);
        add(0, 1, 0, 4'h2, 16'h5678, 0, 0, 1);
        add(0, 1, 0, 4'h3, 16'h5678, 0, 0, 1);
        add(0, 1, 0, 4'h4, 16'h1234, 1, 0, 1);
`ifdef DEMUX_SYNC_CHECK_EN
        add(0, 1, 0, 4'h5, 16'h1234, 0, 1, 0);
        add(0, 1, 0, 4'h6, 16'h1234, 0, 0, 0);
        add(0, 1, 0, 4'h7, 16'h1234, 0, 0, 0);
        add(0, 1, 0, 4'h8, 16'h1234, 0, 0, 0);
`else
        add(0, 1, 0, 4'h5, 16'h1234, 0, 0, 1);
        add(0, 1, 0, 4'h6, 16'h1234, 0, 0, 1);
        add(0, 1, 0, 4'h7, 16'h1234, 0, 0, 1);
        add(0, 1, 0, 4'h8, 16'h5678, 1, 0, 1);
`endif
        add(0, 0, 0, 4'h0, 16'h1234 ^ 16'h0000, 0, 0, 0);

        // Last idle row's expectation depends on the build
`ifdef DEMUX_SYNC_CHECK_EN
        vecs[vecs.size()-1].outs = 16'h1234;
        vecs[vecs.size()-1].lk   = 1'b0;
`else
        vecs[vecs.size()-1].outs = 16'h5678;
        vecs[vecs.size()-1].lk   = 1'b1;
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].d);
            check($sformatf("vec[%0d]", i), vecs[i].outs, vecs[i].ov, vecs[i].fe, vecs[i].lk);
        end

        // Reset in the middle of a frame, then a fresh 7,7,7,7 frame
        step(1, 0, 0, 4'h0);
        step(0, 1, 1, 4'h3);
        step(0, 1, 0, 4'h4);
        check("midframe_pre_reset", vecs[vecs.size()-1].outs & 16'h0000, 0, 0, 1);
        step(1, 1, 0, 4'h5);
        check("midframe_reset", 16'h0000, 0, 0, 0);
        step(0, 1, 0, 4'h7);
        check("after_reset_nosync", 16'h0000, 0, 0, 0);
        step(0, 1, 1, 4'h7);
        step(0, 1, 0, 4'h7);
        step(0, 1, 0, 4'h7);
        check("sevens_partial", 16'h0000, 0, 0, 1);
        step(0, 1, 0, 4'h7);
        check("sevens_frame", 16'h7777, 1, 0, 1);

        // Back-to-back frames: out_valid every 4th cycle, early sync at slot 3
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                logic [3:0] d;
                d = 4'(f * 4 + k);
                step(0, 1, (k == 0), d);
                if (k == 3)
                    check($sformatf("b2b_frame%0d", f), (f == 0) ? 16'h0123 : 16'h4567, 1, 0, 1);
                else
                    check($sformatf("b2b_gap%0d_%0d", f, k), (f == 0) ? 16'h7777 : 16'h0123, 0, 0, 1);
            end
        end
        step(0, 1, 1, 4'hA);
        step(0, 1, 0, 4'hB);
        step(0, 1, 0, 4'hC);
        step(0, 1, 1, 4'hD);
        check("early_sync_slot3", 16'h4567, 0, 1, 1);
        step(0, 0, 0, 4'h0);
        check("early_sync_clear", 16'h4567, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, expected completion before 100000ns");
        $fatal(1);
    end

endmodule
`default_nettype wire
